// File: rtl/g2b_rr_scheduler.sv
// g2b_rr_scheduler
//   Shares one registered Gray-to-binary converter between NREQ requesters.
//   A round-robin arbiter picks one valid requester while idle, the word is
//   converted in the following cycle, and the result is held on a single
//   response channel (tagged with the requester index) until it is accepted.
//   A saturating counter tracks the responses accepted downstream.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   req_valid   per-requester request valid            [NREQ]
//   req_gray    flattened Gray words, k at [k*NBITS +: NBITS]
//   req_ready   per-requester accept, one-hot or zero  [NREQ]
//   rsp_valid   response valid
//   rsp_binary  converted binary word                  [NBITS]
//   rsp_id      index of the owning requester          [IDW]
//   rsp_ready   downstream accepts the response
//   busy        high whenever the scheduler is not idle
//   conv_count  saturating count of accepted responses [CNTW]
module g2b_rr_scheduler #(
    parameter int NBITS = 4,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16,
    localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [NBITS-1:0]      rsp_binary,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy,
    output logic [CNTW-1:0]       conv_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   cand;
    logic             gnt_found;
    logic             accept;
    int               idx;
    logic [NBITS-1:0] gray_p0;
    logic [IDW-1:0]   id_p0;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [NBITS-1:0] gray2bin(input logic [NBITS-1:0] g);
        logic [NBITS-1:0] b;
        b[NBITS-1] = g[NBITS-1];
        for (int i = NBITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Round-robin search starting just after the last grant. Walking the
    // offsets from farthest to nearest lets the nearest valid requester
    // overwrite any farther one, so no early exit is needed.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx  = (int'(last_grant) + off) % NREQ;
            cand = IDW'(idx);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Reset gates the accept so no requester sees ready while reset is held.
    assign accept    = (state == IDLE) && gnt_found && !reset;
    assign req_ready = accept ? (NREQ'(1) << gnt_id) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CONVERT;
            CONVERT: next_state = HOLD;
            HOLD:    if (rsp_valid && rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stage p0: capture the granted word and its index on the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            gray_p0 <= req_gray[int'(gnt_id)*NBITS +: NBITS];
            id_p0   <= gnt_id;
        end
    end

    // Stage p1: converted response, held until the downstream handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_binary <= '0;
            rsp_id     <= '0;
            conv_count <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            if (accept) begin
                last_grant <= gnt_id;
            end
            if (state == CONVERT) begin
                rsp_binary <= gray2bin(gray_p0);
                rsp_id     <= id_p0;
                rsp_valid  <= 1'b1;
            end
            if (state == HOLD && rsp_valid && rsp_ready) begin
                rsp_valid  <= 1'b0;
                conv_count <= sat_inc(conv_count);
            end
        end
    end

endmodule

// File: tb/tb_g2b_rr_scheduler.sv
// Testbench for g2b_rr_scheduler: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_g2b_rr_scheduler;

    localparam int NBITS = 4;
    localparam int NREQ  = 4;
    localparam int CNTW  = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*NBITS-1:0] req_gray;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [NBITS-1:0]      rsp_binary;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
    logic                  busy;
    logic [CNTW-1:0]       conv_count;

    g2b_rr_scheduler #(.NBITS(NBITS), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_binary(rsp_binary),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_last;
    int m_count;

    // Driver observations
    logic [NREQ-1:0]  o_ready;
    int               o_wait;
    logic             o_timeout;
    logic [NREQ-1:0]  o_conv_ready;
    logic             o_conv_vld;
    logic             o_conv_busy;
    logic             o_vld;
    logic [NBITS-1:0] o_bin;
    logic [IDW-1:0]   o_id;
    logic             o_stable;
    logic             o_after_vld;
    logic             o_after_busy;
    time              o_t_accept;

    // Binary value = g ^ (g>>1) ^ (g>>2) ^ ...
    function automatic logic [NBITS-1:0] ref_bin(input logic [NBITS-1:0] g);
        int b;
        b = 0;
        for (int s = 0; s < NBITS; s++) b = b ^ (int'(g) >> s);
        return NBITS'(b);
    endfunction

    function automatic int ref_grant(input int last, input logic [NREQ-1:0] v);
        for (int off = 1; off <= NREQ; off++) begin
            if (v[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic void model_done(input int g);
        m_last = g;
        if (m_count < (1 << CNTW) - 1) m_count = m_count + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full transaction and records what the DUT showed.
    task automatic do_txn(input logic [NREQ-1:0] v, input logic [NREQ*NBITS-1:0] g,
                          input int hold);
        req_valid = v;
        req_gray  = g;
        rsp_ready = 1'b0;
        o_wait    = 0;
        o_timeout = 1'b0;
        o_stable  = 1'b1;
        #1;
        while (req_ready == '0 && !o_timeout) begin
            if (o_wait >= 20) o_timeout = 1'b1;
            else begin
                tick();
                o_wait++;
            end
        end
        o_ready = req_ready;
        if (o_timeout) return;
        tick();
        o_t_accept   = $time;
        o_conv_ready = req_ready;
        o_conv_vld   = rsp_valid;
        o_conv_busy  = busy;
        tick();
        o_vld = rsp_valid;
        o_bin = rsp_binary;
        o_id  = rsp_id;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_binary !== o_bin || rsp_id !== o_id ||
                req_ready !== '0 || busy !== 1'b1) o_stable = 1'b0;
        end
        rsp_ready = 1'b1;
        #1;
        if (req_ready !== '0) o_stable = 1'b0;
        tick();
        o_after_vld  = rsp_valid;
        o_after_busy = busy;
        rsp_ready    = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_gray  = NREQ*NBITS'($urandom);
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || conv_count !== '0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d ready=%b vld=%b busy=%b cnt=%0d required 0000/0/0/0",
                         c, req_ready, rsp_valid, busy, conv_count);
            end
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        m_last    = NREQ - 1;
        m_count   = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b vld=%b required 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_single();
        logic [NREQ*NBITS-1:0] g;
        int eg;
        g  = '0;
        g[2*NBITS +: NBITS] = 4'b1101;
        eg = ref_grant(m_last, 4'b0100);
        do_txn(4'b0100, g, 0);
        model_done(eg);
        checks++;
        if (o_ready !== 4'b0100) begin
            failures++; $display("FAIL single_grant got=%b required=%b", o_ready, 4'b0100);
        end
        checks++;
        if (o_conv_vld !== 1'b0 || o_conv_ready !== '0 || o_conv_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_convert vld=%b ready=%b busy=%b required 0/0000/1",
                     o_conv_vld, o_conv_ready, o_conv_busy);
        end
        checks++;
        if (o_vld !== 1'b1 || o_bin !== 4'b1001 || o_id !== 2'd2) begin
            failures++;
            $display("FAIL single_rsp vld=%b bin=%b id=%0d required 1/1001/2", o_vld, o_bin, o_id);
        end
        checks++;
        if (o_after_vld !== 1'b0 || o_after_busy !== 1'b0 || conv_count !== CNTW'(m_count)) begin
            failures++;
            $display("FAIL single_done vld=%b busy=%b cnt=%0d required 0/0/%0d",
                     o_after_vld, o_after_busy, conv_count, m_count);
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ*NBITS-1:0] g;
        int eg;
        g  = NREQ*NBITS'($urandom);
        eg = ref_grant(m_last, 4'b1001);
        do_txn(4'b1001, g, 5);
        model_done(eg);
        checks++;
        if (o_ready !== NREQ'(1 << eg) || o_id !== IDW'(eg) ||
            o_bin !== ref_bin(g[eg*NBITS +: NBITS])) begin
            failures++;
            $display("FAIL bp_rsp ready=%b id=%0d bin=%b required %b/%0d/%b", o_ready, o_id, o_bin,
                     NREQ'(1 << eg), eg, ref_bin(g[eg*NBITS +: NBITS]));
        end
        checks++;
        if (o_stable !== 1'b1) begin
            failures++; $display("FAIL bp_stable got=%b required=1", o_stable);
        end
        checks++;
        if (o_after_vld !== 1'b0 || o_after_busy !== 1'b0 || conv_count !== CNTW'(m_count)) begin
            failures++;
            $display("FAIL bp_done vld=%b busy=%b cnt=%0d required 0/0/%0d",
                     o_after_vld, o_after_busy, conv_count, m_count);
        end
    endtask

    task automatic test_reset_mid();
        logic quiet;
        int eg;
        req_valid = 4'b0010;
        req_gray  = NREQ*NBITS'($urandom);
        #1;
        tick();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset   = 1'b0;
        m_last  = NREQ - 1;
        m_count = 0;
        quiet   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++;
        if (quiet !== 1'b1 || conv_count !== '0) begin
            failures++;
            $display("FAIL reset_mid_quiet quiet=%b cnt=%0d required 1/0", quiet, conv_count);
        end
        eg = ref_grant(m_last, 4'b1111);
        do_txn(4'b1111, 16'h1234, 0);
        model_done(eg);
        checks++;
        if (o_ready !== 4'b0001 || o_id !== 2'd0 || o_bin !== ref_bin(4'h4)) begin
            failures++;
            $display("FAIL reset_mid_regrant ready=%b id=%0d bin=%b required 0001/0/%b",
                     o_ready, o_id, o_bin, ref_bin(4'h4));
        end
    endtask

    task automatic test_round_robin();
        time t_prev;
        int eg;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            eg = ref_grant(m_last, 4'b1111);
            do_txn(4'b1111, 16'h8888, 0);
            model_done(eg);
            checks++;
            if (o_ready !== NREQ'(1 << eg) || o_id !== IDW'(eg) || o_bin !== 4'b1111) begin
                failures++;
                $display("FAIL rr_grant n=%0d ready=%b id=%0d bin=%b required %b/%0d/1111",
                         n, o_ready, o_id, o_bin, NREQ'(1 << eg), eg);
            end
            if (n > 0) begin
                checks++;
                if (o_t_accept - t_prev != 30) begin
                    failures++;
                    $display("FAIL rr_spacing n=%0d got=%0t required=30", n, o_t_accept - t_prev);
                end
            end
            t_prev = o_t_accept;
        end
        req_valid = '0;
        checks++;
        if (conv_count !== CNTW'(m_count)) begin
            failures++; $display("FAIL rr_count got=%0d required=%0d", conv_count, m_count);
        end
    endtask

    task automatic test_exhaustive();
        logic [NREQ*NBITS-1:0] g;
        int bad;
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_last  = NREQ - 1;
        m_count = 0;
        bad     = 0;
        for (int c = 0; c < 16; c++) begin
            g = '0;
            g[1*NBITS +: NBITS] = NBITS'(c);
            do_txn(4'b0010, g, 0);
            model_done(1);
            checks++;
            if (o_bin !== ref_bin(NBITS'(c)) || o_id !== 2'd1 || o_vld !== 1'b1) begin
                failures++;
                $display("FAIL exh_conv gray=%b bin=%b id=%0d required %b/1", NBITS'(c), o_bin,
                         o_id, ref_bin(NBITS'(c)));
            end
        end
        req_valid = '0;
        checks++;
        if (conv_count !== 16'd16) begin
            failures++; $display("FAIL exh_count got=%0d required=16", conv_count);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0]       v;
        logic [NREQ*NBITS-1:0] g;
        int eg, hold;
        for (int n = 0; n < 40; n++) begin
            v    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            g    = NREQ*NBITS'($urandom);
            hold = $urandom_range(0, 3);
            eg   = ref_grant(m_last, v);
            do_txn(v, g, hold);
            model_done(eg);
            checks++;
            if (o_timeout || o_ready !== NREQ'(1 << eg) || o_id !== IDW'(eg) ||
                o_bin !== ref_bin(g[eg*NBITS +: NBITS]) || o_stable !== 1'b1 ||
                o_after_vld !== 1'b0 || conv_count !== CNTW'(m_count)) begin
                failures++;
                $display("FAIL rand_txn n=%0d to=%b ready=%b id=%0d bin=%b stable=%b cnt=%0d required %b/%0d/%b/1/%0d",
                         n, o_timeout, o_ready, o_id, o_bin, o_stable, conv_count,
                         NREQ'(1 << eg), eg, ref_bin(g[eg*NBITS +: NBITS]), m_count);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_gray  = '0;
        rsp_ready = 1'b0;
        m_last    = NREQ - 1;
        m_count   = 0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_round_robin();
        test_exhaustive();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
